axi_lite_bram_master: RTL and testbench
=======================================

# axi_lite_bram_master

AXI4-Lite slave that converts single-beat host register accesses into the SATA controller's buffer-register strobe interface (`bram_*` signals). It is the initiator for that interface: it issues `bram_wen` write strobes, and `bram_ren` followed by `bram_regen` read strobes. It captures the returned `bram_rdata` and answers the host on the AXI4-Lite channels. It sits between the PS general-purpose AXI port and the register file.

## Interface
Parameters:
- `ADDR_BITS`, default 8: width of the word address driven onto `bram_waddr`/`bram_raddr`; upper address bits are driven zero.
- `REG_RANGE`, default 256: number of implemented word addresses, used only by the range-check feature (see Configuration).

Ports:
- `ACLK` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `awaddr` in 32, `awvalid` in 1, `awready` out 1: write address channel; byte address.
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `araddr` in 32, `arvalid` in 1, `arready` out 1: read address channel; byte address.
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data channel.
- `bram_waddr` out 32, `bram_wdata` out 32, `bram_wstb` out 4, `bram_wen` out 1: register write strobe group.
- `bram_raddr` out 32, `bram_ren` out 1, `bram_regen` out 1, `bram_rdata` in 32: register read group.

## Operation
States: IDLE, WR, WRESP, RD_EN, RD_REG, RD_CAP, RRESP.

Address mapping:
- Word address = byte address [ADDR_BITS+1:2], zero-extended to 32 bits.
- Byte address bits [1:0] are ignored.

IDLE:
- `awready`/`wready` are 1 only when `awvalid & wvalid` are both 1. Both handshakes occur in the same cycle, and address, data and strobes are latched.
- `arready` is 1 only when `arvalid` = 1 and the read is granted.

Arbitration:
- Write and read both pending → round-robin on a `last_was_write` flag (reset 0, so the first contest goes to the write).
- Only one transaction is in flight at a time; no outstanding queue.

Write path:
- IDLE → WR: `bram_wen` = 1 for exactly one cycle with the latched `bram_waddr`/`bram_wdata`/`bram_wstb`.
- WR → WRESP: `bvalid` = 1, `bresp` = 0 (OKAY), held until `bready`.
- WRESP → IDLE.

Read path:
- RD_EN: `bram_ren` = 1 for one cycle with `bram_raddr`.
- RD_REG: `bram_regen` = 1 for one cycle.
- RD_CAP: `rdata` register loads `bram_rdata`.
- RRESP: `rvalid` = 1, `rresp` = 0, held until `rready`, then IDLE.

Output hold behaviour:
- `bram_waddr`/`bram_wdata`/`bram_wstb`/`bram_raddr` hold their last values outside strobe cycles.
- `rdata` holds until the next RD_CAP.

## Timing
Write (AW/W handshake at cycle t):
- `bram_wen` at t+1.
- `bvalid` from t+2.
- Next AXI handshake no earlier than the cycle after `bvalid & bready`.

Read (AR handshake at t):
- `bram_ren` at t+1.
- `bram_regen` at t+2.
- `bram_rdata` sampled at the end of t+3.
- `rvalid` from t+4.

AW without W (or W without AW):
- No handshake on either channel; the bridge waits in IDLE.
- A pending read may be granted meanwhile.

Reset values:
- All ready/valid outputs 0.
- `bram_wen`/`bram_ren`/`bram_regen` 0.
- All address, data, `rdata`, `bresp`, `rresp` 0.
- State IDLE, `last_was_write` 0.

Reset mid-transaction:
- The transaction is abandoned; no response is ever issued for it.
- No `bram_*` strobe is issued in the reset cycle or after it.

Back-pressure:
- `bready`/`rready` low for any number of cycles → `bvalid`/`rvalid` and `rdata`/`rresp`/`bresp` remain stable.

Strobes:
- Strobes are never asserted together.
- `bram_wen` and `bram_ren` are never asserted for consecutive transactions without an IDLE cycle between them.

## Configuration
Macro `AXI_BRAM_RANGE_CHECK_EN`:
- Defined: a word address ≥ `REG_RANGE` suppresses the `bram_wen` or `bram_ren`/`bram_regen` strobes; all state and timing are otherwise identical.
  - Write responds with `bresp` = 2'b10 (SLVERR).
  - Read responds with `rresp` = 2'b10 and `rdata` = 32'hdeadbeef.
- Undefined: no check; every access strobes the interface and responds OKAY; `REG_RANGE` is unused.

## Test plan
- Write: awaddr 0x3C0, wdata 0x12345678, wstrb 4'b0011 → one-cycle `bram_wen` at t+1 with `bram_waddr` = 0xF0, `bram_wdata` = 0x12345678, `bram_wstb` = 4'b0011; `bvalid` at t+2 with `bresp` = 0.
- Read: araddr 0x3D0 with model returning 0xffffffff one cycle after `bram_regen` → `bram_ren` t+1 with `bram_raddr` = 0xF4, `bram_regen` t+2, `rvalid` t+4 with `rdata` = 0xffffffff.
- Simultaneous AW+W and AR from reset → write served first, then read; next simultaneous pair → write first again (flag set by the read); `bram_wen` and `bram_ren` never overlap.
- Back-pressure: `rready` held 0 for 10 cycles → `rvalid`/`rdata` stable; no new AR accepted until `rready` = 1.
- Reset asserted in RD_REG → `bram_regen` deasserts the same cycle; no `rvalid` afterwards; next read completes normally.
- With `AXI_BRAM_RANGE_CHECK_EN`, `REG_RANGE` = 32: write to byte 0x100 → no `bram_wen`, `bresp` = 2'b10; read of 0x100 → `rresp` = 2'b10, `rdata` = 0xdeadbeef.

Source files
------------

// File: rtl/axi_lite_bram_if.sv
// axi_lite_bram_if: AXI4-Lite slave channels plus the SATA buffer-register strobe group
interface axi_lite_bram_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] bram_waddr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_wstb;
    logic        bram_wen;
    logic [31:0] bram_raddr;
    logic        bram_ren;
    logic        bram_regen;
    logic [31:0] bram_rdata;
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready, bram_rdata,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
               bram_waddr, bram_wdata, bram_wstb, bram_wen, bram_raddr, bram_ren, bram_regen
    );
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready, bram_rdata,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
               bram_waddr, bram_wdata, bram_wstb, bram_wen, bram_raddr, bram_ren, bram_regen
    );
endinterface

// File: rtl/axi_lite_bram_master.sv
// axi_lite_bram_master: AXI4-Lite slave issuing single-beat SATA buffer-register strobes.
// Define AXI_BRAM_RANGE_CHECK_EN to answer word addresses >= REG_RANGE with SLVERR and no strobe.
module axi_lite_bram_master #(
    parameter int ADDR_BITS = 8,
    parameter int REG_RANGE = 256
) (
    input logic ACLK,
    input logic rst,
    axi_lite_bram_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WR, WRESP, RD_EN, RD_REG, RD_CAP, RRESP} state_t;
    state_t state, state_n;
    logic last_was_write, err, grant_wr, grant_rd, aw_oor, ar_oor, unused_addr;
    logic [31:0] aw_word, ar_word;
    assign aw_word = 32'(bus.awaddr[ADDR_BITS+1:2]);
    assign ar_word = 32'(bus.araddr[ADDR_BITS+1:2]);
`ifdef AXI_BRAM_RANGE_CHECK_EN
    assign aw_oor = aw_word >= 32'(REG_RANGE);
    assign ar_oor = ar_word >= 32'(REG_RANGE);
    assign unused_addr = ^{bus.awaddr, bus.araddr};
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
    assign unused_addr = ^{bus.awaddr, bus.araddr, 32'(REG_RANGE)};
`endif
    // Grants are only issued from IDLE; a contested cycle goes to whichever side was not served last.
    always_comb begin
        state_n = state;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!rst)
            case (state)
                IDLE: begin
                    grant_wr = bus.awvalid && bus.wvalid && !(bus.arvalid && last_was_write);
                    grant_rd = bus.arvalid && !grant_wr;
                    state_n = grant_wr ? WR : grant_rd ? RD_EN : IDLE;
                end
                WR:      state_n = WRESP;
                WRESP:   state_n = bus.bready ? IDLE : WRESP;
                RD_EN:   state_n = RD_REG;
                RD_REG:  state_n = RD_CAP;
                RD_CAP:  state_n = RRESP;
                RRESP:   state_n = bus.rready ? IDLE : RRESP;
                default: state_n = IDLE;
            endcase
    end
    assign bus.awready = grant_wr;
    assign bus.wready = grant_wr;
    assign bus.arready = grant_rd;
    assign bus.bvalid = !rst && state == WRESP;
    assign bus.rvalid = !rst && state == RRESP;
    // Strobes are masked by rst so an abandoned transaction never reaches the register file.
    assign bus.bram_wen = !rst && state == WR && !err;
    assign bus.bram_ren = !rst && state == RD_EN && !err;
    assign bus.bram_regen = !rst && state == RD_REG && !err;
    always_ff @(posedge ACLK) begin
        if (rst) begin
            state <= IDLE;
            last_was_write <= 1'b0;
            err <= 1'b0;
            bus.bram_waddr <= '0;
            bus.bram_wdata <= '0;
            bus.bram_wstb <= '0;
            bus.bram_raddr <= '0;
            bus.rdata <= '0;
            bus.bresp <= '0;
            bus.rresp <= '0;
        end else begin
            state <= state_n;
            if (grant_wr) begin
                last_was_write <= 1'b1;
                err <= aw_oor;
                bus.bram_waddr <= aw_word;
                bus.bram_wdata <= bus.wdata;
                bus.bram_wstb <= bus.wstrb;
            end
            if (grant_rd) begin
                last_was_write <= 1'b0;
                err <= ar_oor;
                bus.bram_raddr <= ar_word;
            end
            if (state == WR) bus.bresp <= err ? 2'b10 : 2'b00;
            if (state == RD_CAP) begin
                bus.rdata <= err ? 32'hdeadbeef : bus.bram_rdata;
                bus.rresp <= err ? 2'b10 : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_bram_master.sv
// tb_axi_lite_bram_master: transaction-timeline model checked every cycle, plus directed literal pins
module tb_axi_lite_bram_master;
`ifdef AXI_BRAM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
    localparam int RR = 32;
`else
    localparam bit RC = 1'b0;
    localparam int RR = 256;
`endif
    logic ACLK = 1'b0;
    logic rst = 1'b1;
    int n_pass = 0, n_total = 0, cyc = 0;
    axi_lite_bram_if bus();
    axi_lite_bram_master #(.ADDR_BITS(8), .REG_RANGE(RR)) dut (.ACLK(ACLK), .rst(rst), .bus(bus));
    always #5 ACLK = ~ACLK;

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", n, act, exp, cyc);
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return {24'h0, a[9:2]};
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return RC && word(a) >= RR;
    endfunction

    function automatic logic [31:0] ex(input logic [31:0] a, input logic [31:0] v);
        return oor(a) ? 32'hdeadbeef : v;
    endfunction

    // Model: one transaction at a time, events placed at fixed offsets from the grant cycle m_t.
    bit m_busy = 0, m_rd = 0, m_err = 0, m_last = 0, regen_prev = 0;
    int m_t = 0;
    logic [31:0] m_waddr = '0, m_wdata = '0, m_raddr = '0, m_rdata = '0;
    logic [3:0] m_wstb = '0;
    logic [1:0] m_bresp = '0, m_rresp = '0;
    logic [7:0] raddr_prev = '0;
    logic [31:0] mem [256];

    always @(negedge ACLK) begin
        bit g_wr, g_rd, e_bv, e_rv;
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] = 32'hc0de0000 | i;
            mem[8'hf4] = 32'hffffffff;
        end
        cyc++;
        if (rst) begin
            chk("rst_awready", bus.awready, 0);
            chk("rst_wready", bus.wready, 0);
            chk("rst_arready", bus.arready, 0);
            chk("rst_bvalid", bus.bvalid, 0);
            chk("rst_rvalid", bus.rvalid, 0);
            chk("rst_wen", bus.bram_wen, 0);
            chk("rst_ren", bus.bram_ren, 0);
            chk("rst_regen", bus.bram_regen, 0);
            m_busy = 0; m_last = 0; m_err = 0;
            m_waddr = '0; m_wdata = '0; m_wstb = '0; m_raddr = '0;
            m_rdata = '0; m_bresp = '0; m_rresp = '0;
        end else begin
            g_wr = !m_busy && bus.awvalid && bus.wvalid;
            g_rd = !m_busy && bus.arvalid;
            if (g_wr && g_rd) begin
                g_wr = !m_last;
                g_rd = m_last;
            end
            e_bv = m_busy && !m_rd && cyc >= m_t + 2;
            e_rv = m_busy && m_rd && cyc >= m_t + 4;
            chk("awready", bus.awready, g_wr);
            chk("wready", bus.wready, g_wr);
            chk("arready", bus.arready, g_rd);
            chk("bram_wen", bus.bram_wen, m_busy && !m_rd && !m_err && cyc == m_t + 1);
            chk("bram_ren", bus.bram_ren, m_busy && m_rd && !m_err && cyc == m_t + 1);
            chk("bram_regen", bus.bram_regen, m_busy && m_rd && !m_err && cyc == m_t + 2);
            chk("bvalid", bus.bvalid, e_bv);
            chk("rvalid", bus.rvalid, e_rv);
            chk("bram_waddr", bus.bram_waddr, m_waddr);
            chk("bram_wdata", bus.bram_wdata, m_wdata);
            chk("bram_wstb", bus.bram_wstb, m_wstb);
            chk("bram_raddr", bus.bram_raddr, m_raddr);
            chk("rdata", bus.rdata, m_rdata);
            chk("bresp", bus.bresp, m_bresp);
            chk("rresp", bus.rresp, m_rresp);
            if (m_busy && !m_rd && cyc == m_t + 1) m_bresp = m_err ? 2'b10 : 2'b00;
            if (m_busy && m_rd && cyc == m_t + 3) begin
                m_rdata = m_err ? 32'hdeadbeef : mem[m_raddr[7:0]];
                m_rresp = m_err ? 2'b10 : 2'b00;
            end
            if ((e_bv && bus.bready) || (e_rv && bus.rready)) m_busy = 0;
            if (g_wr) begin
                m_busy = 1; m_rd = 0; m_t = cyc; m_last = 1; m_err = oor(bus.awaddr);
                m_waddr = word(bus.awaddr); m_wdata = bus.wdata; m_wstb = bus.wstrb;
            end
            if (g_rd) begin
                m_busy = 1; m_rd = 1; m_t = cyc; m_last = 0; m_err = oor(bus.araddr);
                m_raddr = word(bus.araddr);
            end
        end
        // Register-file stand-in: applies strobed writes, returns read data the cycle after regen.
        if (bus.bram_wen === 1'b1)
            for (int i = 0; i < 4; i++)
                if (bus.bram_wstb[i]) mem[bus.bram_waddr[7:0]][8*i +: 8] = bus.bram_wdata[8*i +: 8];
        bus.bram_rdata = regen_prev ? mem[raddr_prev] : 32'h0bad0bad;
        regen_prev = bus.bram_regen === 1'b1;
        raddr_prev = bus.bram_raddr[7:0];
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [31:0] wa);
        int n = 0;
        @(posedge ACLK); #1;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awvalid = 1; bus.wvalid = 1;
        do begin @(negedge ACLK); n++; end while (bus.awready !== 1'b1 && n < 20);
        chk("pin_wr_hs", bus.awready, 1);
        @(negedge ACLK);
        chk("pin_wen", bus.bram_wen, !oor(a));
        chk("pin_waddr", bus.bram_waddr, wa);
        chk("pin_wdata", bus.bram_wdata, d);
        chk("pin_wstb", bus.bram_wstb, s);
        @(posedge ACLK); #1;
        bus.awvalid = 0; bus.wvalid = 0;
        @(negedge ACLK);
        chk("pin_bvalid", bus.bvalid, 1);
        chk("pin_bresp", bus.bresp, oor(a) ? 2 : 0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ra, input logic [31:0] v);
        int n = 0;
        @(posedge ACLK); #1;
        bus.araddr = a; bus.arvalid = 1;
        do begin @(negedge ACLK); n++; end while (bus.arready !== 1'b1 && n < 20);
        chk("pin_rd_hs", bus.arready, 1);
        @(negedge ACLK);
        chk("pin_ren", bus.bram_ren, !oor(a));
        chk("pin_raddr", bus.bram_raddr, ra);
        @(posedge ACLK); #1;
        bus.arvalid = 0;
        @(negedge ACLK);
        chk("pin_regen", bus.bram_regen, !oor(a));
        @(negedge ACLK);
        @(negedge ACLK);
        chk("pin_rvalid", bus.rvalid, 1);
        chk("pin_rdata", bus.rdata, ex(a, v));
        chk("pin_rresp", bus.rresp, oor(a) ? 2 : 0);
    endtask

    task automatic both(input bit wr_first);
        int n = 0;
        @(posedge ACLK); #1;
        bus.awaddr = 32'h020; bus.wdata = 32'ha5a50001; bus.wstrb = 4'hf; bus.araddr = 32'h024;
        bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
        do begin @(negedge ACLK); n++; end while (!(bus.awready === 1'b1 || bus.arready === 1'b1) && n < 20);
        chk("pin_rr_first_aw", bus.awready, wr_first);
        chk("pin_rr_first_ar", bus.arready, !wr_first);
        @(posedge ACLK); #1;
        if (wr_first) begin bus.awvalid = 0; bus.wvalid = 0; end
        else bus.arvalid = 0;
        n = 0;
        do begin @(negedge ACLK); n++; end
        while ((wr_first ? bus.arready : bus.awready) !== 1'b1 && n < 30);
        chk("pin_rr_second", wr_first ? bus.arready : bus.awready, 1);
        @(posedge ACLK); #1;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        repeat (8) @(posedge ACLK);
    endtask

    initial begin
        int n;
        bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0; bus.bready = 1;
        bus.araddr = 0; bus.arvalid = 0; bus.rready = 1;
        repeat (3) @(posedge ACLK);
        #1 rst = 0;
        @(negedge ACLK);
        chk("pin_rst_rdata", bus.rdata, 0);
        chk("pin_rst_waddr", bus.bram_waddr, 0);
        chk("pin_rst_bresp", bus.bresp, 0);
        wr(32'h3c0, 32'h12345678, 4'b0011, 32'hf0);
        rd(32'h3d0, 32'hf4, 32'hffffffff);
        rd(32'h3c0, 32'hf0, 32'hc0de5678);
        both(1);
        both(1);
        wr(32'h010, 32'h000000aa, 4'b1111, 32'h4);
        both(0);
        // Read held under back-pressure with a second read waiting behind it.
        @(posedge ACLK); #1;
        bus.rready = 0; bus.araddr = 32'h3d0; bus.arvalid = 1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (bus.arready !== 1'b1 && n < 20);
        chk("pin_bp_hs", bus.arready, 1);
        @(posedge ACLK); #1;
        bus.araddr = 32'h008;
        n = 0;
        do begin @(negedge ACLK); n++; end while (bus.rvalid !== 1'b1 && n < 20);
        chk("pin_bp_rvalid", bus.rvalid, 1);
        repeat (10) begin
            @(negedge ACLK);
            chk("pin_bp_hold", bus.rvalid, 1);
            chk("pin_bp_rdata", bus.rdata, ex(32'h3d0, 32'hffffffff));
            chk("pin_bp_noar", bus.arready, 0);
        end
        @(posedge ACLK); #1;
        bus.rready = 1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (bus.arready !== 1'b1 && n < 20);
        chk("pin_bp_next_hs", bus.arready, 1);
        @(posedge ACLK); #1;
        bus.arvalid = 0;
        repeat (6) @(posedge ACLK);
        // Reset landing in the regen cycle abandons the read.
        #1;
        bus.araddr = 32'h3d0; bus.arvalid = 1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (bus.arready !== 1'b1 && n < 20);
        @(posedge ACLK); #1;
        bus.arvalid = 0;
        @(posedge ACLK); #1;
        rst = 1;
        @(negedge ACLK);
        chk("pin_rst_regen", bus.bram_regen, 0);
        @(posedge ACLK); #1;
        rst = 0;
        repeat (6) begin
            @(negedge ACLK);
            chk("pin_no_rvalid", bus.rvalid, 0);
        end
        rd(32'h008, 32'h2, 32'hc0de0002);
        wr(32'h100, 32'hcafef00d, 4'hf, 32'h40);
        rd(32'h100, 32'h40, 32'hcafef00d);
        repeat (4) @(posedge ACLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end
endmodule
